// File: rtl/exec_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : exec_sequencer_if
// Description : Instruction handshake and register-file bus bundle between the
//               execute sequencer and its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface exec_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] Ra;
    logic [ADDR_W-1:0] Rb;
    logic [DATA_W-1:0] busA;
    logic [DATA_W-1:0] busB;
    logic [ADDR_W-1:0] Rw;
    logic              wrEn;
    logic [DATA_W-1:0] busW;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              carry;
    logic              ovf;
    logic              done;

    // Environment side: issues instructions and serves the register file
    modport master (
        output instr_valid, op, rd, rs, rt, busA, busB,
        input  instr_ready, Ra, Rb, Rw, wrEn, busW, result, zero, carry, ovf, done
    );

    // Sequencer side
    modport slave (
        input  instr_valid, op, rd, rs, rt, busA, busB,
        output instr_ready, Ra, Rb, Rw, wrEn, busW, result, zero, carry, ovf, done
    );
endinterface
`default_nettype wire

// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : exec_sequencer
// Description : Four-state fetch / execute / write-back controller in front of
//               a 32 x 16-bit register file. One ALU instruction per 4 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  wire              clk,
    input  wire              rst,
    exec_sequencer_if.slave  bus
);

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_AND = 3'd2;
    localparam logic [2:0] c_OP_OR  = 3'd3;
    localparam logic [2:0] c_OP_XOR = 3'd4;
    localparam logic [2:0] c_OP_SLL = 3'd5;
    localparam logic [2:0] c_OP_SRL = 3'd6;
    localparam logic [2:0] c_OP_SLT = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic              w_ready;
    logic              w_accept;
    logic              w_capture;
    logic              w_execute;
    logic              w_wrEn;
    logic              w_done;

    logic [2:0]        r_op;
    logic [ADDR_W-1:0] r_rd;
    logic [ADDR_W-1:0] r_Ra;
    logic [ADDR_W-1:0] r_Rb;
    logic [ADDR_W-1:0] r_Rw;
    logic [DATA_W-1:0] r_opA;
    logic [DATA_W-1:0] r_opB;
    logic [DATA_W-1:0] r_busW;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic              r_carry;
    logic              r_ovf;

    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_diff;
    logic [DATA_W-1:0] w_res;
    logic              w_carry;
    logic              w_ovf;

    // State register; reset parks the controller in IDLE at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and state-decoded controls
    always_comb begin
        w_nextState = r_state;
        w_ready     = 1'b0;
        w_capture   = 1'b0;
        w_execute   = 1'b0;
        w_wrEn      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Held low while reset is asserted so no handshake can be seen
                w_ready = ~rst;
                if (bus.instr_valid && w_ready) begin
                    w_nextState = S_READ;
                end
            end
            S_READ: begin
                w_capture   = 1'b1;
                w_nextState = S_EXEC;
            end
            S_EXEC: begin
                w_execute   = 1'b1;
                w_nextState = S_WB;
            end
            S_WB: begin
                // R0 is hard-wired: retire without writing it
                w_wrEn      = (r_rd != '0);
                w_done      = 1'b1;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    assign w_accept = bus.instr_valid && w_ready;

    // ALU: evaluates the latched operands during EXEC
    always_comb begin
        w_sum   = {1'b0, r_opA} + {1'b0, r_opB};
        w_diff  = r_opA - r_opB;
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (r_op)
            c_OP_ADD: begin
                w_res   = w_sum[DATA_W-1:0];
                w_carry = w_sum[DATA_W];
                w_ovf   = (r_opA[DATA_W-1] == r_opB[DATA_W-1]) &&
                          (w_sum[DATA_W-1] != r_opA[DATA_W-1]);
            end
            c_OP_SUB: begin
                w_res   = w_diff;
                w_carry = (r_opA < r_opB);
                w_ovf   = (r_opA[DATA_W-1] != r_opB[DATA_W-1]) &&
                          (w_diff[DATA_W-1] != r_opA[DATA_W-1]);
            end
            c_OP_AND: w_res = r_opA & r_opB;
            c_OP_OR:  w_res = r_opA | r_opB;
            c_OP_XOR: w_res = r_opA ^ r_opB;
            c_OP_SLL: w_res = r_opA << r_opB[3:0];
            c_OP_SRL: w_res = r_opA >> r_opB[3:0];
            c_OP_SLT: w_res = {{(DATA_W-1){1'b0}}, ($signed(r_opA) < $signed(r_opB))};
            default:  w_res = '0;
        endcase
    end

    // Datapath registers: instruction latch, operand capture, result/write-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_rd     <= '0;
            r_Ra     <= '0;
            r_Rb     <= '0;
            r_Rw     <= '0;
            r_opA    <= '0;
            r_opB    <= '0;
            r_busW   <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op <= bus.op;
                r_rd <= bus.rd;
                r_Ra <= bus.rs;
                r_Rb <= bus.rt;
            end
            if (w_capture) begin
                r_opA <= bus.busA;
                r_opB <= bus.busB;
            end
            // Rw/busW are loaded together with the result so they are stable
            // for the whole WB cycle and hold afterwards
            if (w_execute) begin
                r_result <= w_res;
                r_zero   <= (w_res == '0);
                r_carry  <= w_carry;
                r_ovf    <= w_ovf;
                r_Rw     <= r_rd;
                r_busW   <= w_res;
            end
        end
    end

    assign bus.instr_ready = w_ready;
    assign bus.Ra          = r_Ra;
    assign bus.Rb          = r_Rb;
    assign bus.Rw          = r_Rw;
    assign bus.wrEn        = w_wrEn;
    assign bus.busW        = r_busW;
    assign bus.result      = r_result;
    assign bus.zero        = r_zero;
    assign bus.carry       = r_carry;
    assign bus.ovf         = r_ovf;
    assign bus.done        = w_done;

endmodule
`default_nettype wire

// File: tb/tb_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_sequencer
// Description : Self-checking bench: register file model, arithmetic reference
//               model, directed corner cases and randomized instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_sequencer;

    logic clk;
    logic rst;

    exec_sequencer_if #(.DATA_W(16), .ADDR_W(5)) bus ();

    exec_sequencer #(.DATA_W(16), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file seen by the DUT, with a bench preload port
    logic [15:0] tbRegs [32];
    logic        preEn;
    logic [4:0]  preAddr;
    logic [15:0] preData;

    always @(posedge clk) begin
        if (preEn) begin
            tbRegs[preAddr] <= preData;
        end else if (bus.wrEn) begin
            tbRegs[bus.Rw] <= bus.busW;
        end
    end

    assign bus.busA = tbRegs[bus.Ra];
    assign bus.busB = tbRegs[bus.Rb];

    // Expected register contents
    logic [15:0] mRegs [32];

    int nChecks = 0;
    int nFails  = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference arithmetic from integer rules
    function automatic void model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic z, output logic c, output logic v);
        longint ua, ub, sa, sb, full;
        ua = longint'(a);
        ub = longint'(b);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        c = 1'b0;
        v = 1'b0;
        full = 0;
        case (o)
            3'd0: begin
                full = ua + ub;
                c = (full > 65535);
                v = (sa + sb > 32767) || (sa + sb < -32768);
            end
            3'd1: begin
                full = ua - ub + 65536;
                c = (ua < ub);
                v = (sa - sb > 32767) || (sa - sb < -32768);
            end
            3'd2: full = longint'(a & b);
            3'd3: full = longint'(a | b);
            3'd4: full = longint'(a ^ b);
            3'd5: full = ua * (longint'(1) << (ub % 16));
            3'd6: full = ua / (longint'(1) << (ub % 16));
            default: full = (sa < sb) ? 1 : 0;
        endcase
        r = 16'(full % 65536);
        z = (r == 16'h0);
    endfunction

    task automatic preload(input logic [4:0] a, input logic [15:0] d);
        @(negedge clk);
        preEn = 1'b1;
        preAddr = a;
        preData = d;
        @(posedge clk);
        #1 preEn = 1'b0;
        mRegs[a] = d;
    endtask

    task automatic waitReady();
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.instr_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        checkVal("readyWait", {31'd0, bus.instr_ready}, 32'd1);
    endtask

    // Issue one instruction and check every cycle until it retires
    task automatic doInstr(input logic [2:0] o, input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
        logic [15:0] er;
        logic ez, ec, ev;
        model(o, mRegs[s], mRegs[t], er, ez, ec, ev);
        waitReady();
        bus.instr_valid = 1'b1;
        bus.op = o;
        bus.rd = d;
        bus.rs = s;
        bus.rt = t;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        checkVal("Ra", {27'd0, bus.Ra}, {27'd0, s});
        checkVal("Rb", {27'd0, bus.Rb}, {27'd0, t});
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            checkVal("busyReady", {31'd0, bus.instr_ready}, 32'd0);
            checkVal("busyWrEn", {31'd0, bus.wrEn}, 32'd0);
            checkVal("busyDone", {31'd0, bus.done}, 32'd0);
        end
        @(negedge clk);
        checkVal("wbWrEn", {31'd0, bus.wrEn}, {31'd0, (d != 5'd0)});
        checkVal("wbDone", {31'd0, bus.done}, 32'd1);
        checkVal("wbReady", {31'd0, bus.instr_ready}, 32'd0);
        checkVal("wbRw", {27'd0, bus.Rw}, {27'd0, d});
        checkVal("wbBusW", {16'd0, bus.busW}, {16'd0, er});
        checkVal("result", {16'd0, bus.result}, {16'd0, er});
        checkVal("flags", {29'd0, bus.zero, bus.carry, bus.ovf}, {29'd0, ez, ec, ev});
        @(negedge clk);
        checkVal("idleDone", {31'd0, bus.done}, 32'd0);
        checkVal("idleWrEn", {31'd0, bus.wrEn}, 32'd0);
        checkVal("idleReady", {31'd0, bus.instr_ready}, 32'd1);
        if (d != 5'd0) mRegs[d] = er;
        checkVal("regfile", {16'd0, tbRegs[d]}, {16'd0, mRegs[d]});
    endtask

    initial begin
        logic [15:0] er;
        logic ez, ec, ev;
        int accepts [$];
        int readyCnt, doneCnt, nAcc;
        logic sawActivity;

        rst = 1'b1;
        preEn = 1'b0;
        preAddr = '0;
        preData = '0;
        bus.instr_valid = 1'b0;
        bus.op = '0;
        bus.rd = '0;
        bus.rs = '0;
        bus.rt = '0;

        // Reset values
        repeat (2) @(negedge clk);
        checkVal("rstReady", {31'd0, bus.instr_ready}, 32'd0);
        checkVal("rstOutputs", {bus.Ra, bus.Rb, bus.Rw, bus.wrEn, bus.done, bus.zero, bus.carry, bus.ovf},
                 32'd0);
        checkVal("rstData", {bus.busW, bus.result}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkVal("readyAfterRst", {31'd0, bus.instr_ready}, 32'd1);

        for (int i = 0; i < 32; i++) preload(5'(i), 16'($urandom));

        // Directed arithmetic corners
        preload(5'd1, 16'h7FFF);
        preload(5'd2, 16'h0001);
        doInstr(3'd0, 5'd3, 5'd1, 5'd2);
        checkVal("add8000", {16'd0, tbRegs[3]}, 32'h8000);
        preload(5'd4, 16'h0003);
        preload(5'd5, 16'h0005);
        doInstr(3'd1, 5'd6, 5'd4, 5'd5);
        doInstr(3'd1, 5'd7, 5'd1, 5'd1);
        preload(5'd8, 16'h0001);
        preload(5'd9, 16'h0013);
        preload(5'd10, 16'h8000);
        preload(5'd11, 16'h000F);
        doInstr(3'd5, 5'd14, 5'd8, 5'd9);
        doInstr(3'd6, 5'd15, 5'd10, 5'd11);
        doInstr(3'd7, 5'd16, 5'd10, 5'd8);
        doInstr(3'd7, 5'd17, 5'd8, 5'd10);
        // Destination equals source
        doInstr(3'd0, 5'd4, 5'd4, 5'd4);
        // R0 destination: retire without write
        doInstr(3'd0, 5'd0, 5'd1, 5'd2);

        // Continuous valid: three accumulating instructions
        nAcc = 0;
        readyCnt = 0;
        doneCnt = 0;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.op = 3'd0;
        bus.rd = 5'd12;
        bus.rs = 5'd12;
        bus.rt = 5'd13;
        for (int c = 0; c < 13; c++) begin
            if (c > 0) @(negedge clk);
            if (nAcc == 3) bus.instr_valid = 1'b0;
            if (c < 12 && bus.instr_ready) readyCnt++;
            if (bus.done) doneCnt++;
            if (bus.instr_ready && bus.instr_valid) begin
                accepts.push_back(c);
                nAcc++;
            end
        end
        checkVal("b2bCount", accepts.size(), 32'd3);
        if (accepts.size() == 3) begin
            checkVal("b2bAcc1", accepts[1], 32'd4);
            checkVal("b2bAcc2", accepts[2], 32'd8);
        end
        checkVal("b2bReadyCycles", readyCnt, 32'd3);
        checkVal("b2bDone", doneCnt, 32'd3);
        for (int k = 0; k < 3; k++) begin
            model(3'd0, mRegs[12], mRegs[13], er, ez, ec, ev);
            mRegs[12] = er;
        end
        checkVal("b2bReg", {16'd0, tbRegs[12]}, {16'd0, mRegs[12]});

        // Reset during EXEC abandons the instruction
        preload(5'd20, 16'h1234);
        waitReady();
        bus.instr_valid = 1'b1;
        bus.op = 3'd3;
        bus.rd = 5'd20;
        bus.rs = 5'd1;
        bus.rt = 5'd2;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkVal("midRstCtl", {29'd0, bus.wrEn, bus.done, bus.instr_ready}, 32'd0);
        checkVal("midRstRes", {12'd0, bus.result, bus.zero, bus.carry, bus.ovf, 1'b0}, 32'd0);
        checkVal("midRstAddr", {17'd0, bus.Ra, bus.Rb, bus.Rw}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sawActivity = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.wrEn || bus.done) sawActivity = 1'b1;
        end
        checkVal("midRstQuiet", {31'd0, sawActivity}, 32'd0);
        checkVal("midRstReg", {16'd0, tbRegs[20]}, 32'h1234);
        doInstr(3'd3, 5'd20, 5'd1, 5'd2);

        // Randomized instructions
        for (int i = 0; i < 24; i++) begin
            if (i % 4 == 0) preload(5'($urandom_range(1, 31)), 16'($urandom));
            doInstr(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
